// File: rtl/ws2812_rx.sv
// ws2812_rx: cycle-counting WS2812 line decoder that assembles 24-bit pixels in wire order and flags the latch gap.
// Optional WS2812_RX_SYNC_EN inserts a 2-flop synchronizer on din, which delays every strobe by 2 cycles.
module ws2812_rx #(
  parameter int BITS_PER_PIXEL  = 24,
  parameter int PX_COUNT_WIDTH  = 6,
  parameter int PX_MAX          = 52,
  parameter int T1_MIN_CYCLES   = 60,
  parameter int T_MIN_CYCLES    = 10,
  parameter int HIGH_MAX_CYCLES = 120,
  parameter int LATCH_CYCLES    = 5000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] px_data,
  output logic [PX_COUNT_WIDTH-1:0] px_num,
  output logic                      px_valid,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH:0]   frame_px_count,
  output logic                      err
);

  localparam logic [15:0] T1_MIN   = 16'(T1_MIN_CYCLES);
  localparam logic [15:0] T_MIN    = 16'(T_MIN_CYCLES);
  localparam logic [15:0] HIGH_MAX = 16'(HIGH_MAX_CYCLES);
  localparam logic [15:0] LATCH    = 16'(LATCH_CYCLES);
  localparam logic [4:0]  LAST_BIT = 5'(BITS_PER_PIXEL - 1);
  localparam logic [PX_COUNT_WIDTH:0] PX_LIMIT = (PX_COUNT_WIDTH + 1)'(PX_MAX);

  typedef enum logic [1:0] {ARM, IDLE, HIGH, LOW} state_t;

  state_t                    state;
  logic                      s;
  logic                      s_prev;
  logic [15:0]               hcnt;
  logic [15:0]               lcnt;
  logic [4:0]                bit_cnt;
  logic [PX_COUNT_WIDTH:0]   px_idx;
  logic [BITS_PER_PIXEL-2:0] shreg;
  logic [BITS_PER_PIXEL-1:0] shreg_next;
  logic                      rise;
  logic                      fall;
  logic                      bad_pulse;

`ifdef WS2812_RX_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[0], din};
  end

  assign s = sync_ff[1];
`else
  assign s = din;
`endif

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;

  // Only the low 23 bits are kept; the incoming bit completes the pixel on the 24th fall.
  assign shreg_next = {shreg, (hcnt >= T1_MIN)};
  assign bad_pulse  = (hcnt > HIGH_MAX) || (fall && (hcnt < T_MIN));

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // NOTE: all state below is updated with <= so every branch reads the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARM;
      s_prev         <= 1'b0;
      hcnt           <= '0;
      lcnt           <= '0;
      bit_cnt        <= '0;
      px_idx         <= '0;
      shreg          <= '0;
      px_data        <= '0;
      px_num         <= '0;
      px_valid       <= 1'b0;
      frame_done     <= 1'b0;
      frame_px_count <= '0;
      err            <= 1'b0;
    end else begin
      s_prev     <= s;
      px_valid   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        ARM: begin
          if (s)                   lcnt  <= '0;
          else if (lcnt == LATCH)  state <= IDLE;
          else                     lcnt  <= sat_inc(lcnt);
        end
        IDLE: begin
          if (rise) begin
            state <= HIGH;
            hcnt  <= 16'd1;
          end
        end
        HIGH: begin
          if (bad_pulse) begin
            err     <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
            px_idx  <= '0;
            lcnt    <= '0;
            state   <= ARM;
          end else if (fall) begin
            shreg <= shreg_next[BITS_PER_PIXEL-2:0];
            lcnt  <= 16'd1;
            state <= LOW;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (px_idx < PX_LIMIT) begin
                px_data  <= shreg_next;
                px_num   <= px_idx[PX_COUNT_WIDTH-1:0];
                px_valid <= 1'b1;
                px_idx   <= px_idx + 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            hcnt <= sat_inc(hcnt);
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            hcnt  <= 16'd1;
          end else if (lcnt == LATCH) begin
            frame_done     <= 1'b1;
            frame_px_count <= px_idx;
            px_idx         <= '0;
            err            <= (bit_cnt != 5'd0);
            bit_cnt        <= '0;
            shreg          <= '0;
            state          <= IDLE;
          end else begin
            lcnt <= sat_inc(lcnt);
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed scenario bench for ws2812_rx; strobe latencies account for the optional input synchronizer.
module tb_ws2812_rx;

  localparam int LATCH = 5000;
`ifdef WS2812_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] px_data;
  logic [5:0]  px_num;
  logic        px_valid;
  logic        frame_done;
  logic [6:0]  frame_px_count;
  logic        err;

  ws2812_rx dut (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .px_data        (px_data),
    .px_num         (px_num),
    .px_valid       (px_valid),
    .frame_done     (frame_done),
    .frame_px_count (frame_px_count),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pv_cnt   = 0;
  int pv_cyc   = -1;
  int fd_cnt   = 0;
  int fd_cyc   = -1;
  int err_cnt  = 0;
  int err_cyc  = -1;
  int both_cnt = 0;
  int last_fall_cyc = 0;
  logic [6:0]  fd_fpc = '0;
  logic [23:0] log_data [256];
  logic [5:0]  log_num  [256];

  always @(posedge clk) cyc++;

  // Strobe monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (px_valid === 1'b1) begin
      if (pv_cnt < 256) begin
        log_data[pv_cnt] = px_data;
        log_num[pv_cnt]  = px_num;
      end
      pv_cnt++;
      pv_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
      fd_fpc = frame_px_count;
    end
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (frame_done === 1'b1 && err === 1'b1) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Drive din to v for n rising edges; returns 1 time unit after the last edge.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int th, input int tl);
    hold(1'b1, th);
    last_fall_cyc = cyc;
    hold(1'b0, tl);
  endtask

  // Sends v[nb-1:0] MSB first; slow uses nominal 100 MHz timings, fast uses short legal pulses.
  task automatic send_bits(input logic [23:0] v, input int nb, input bit slow);
    for (int i = nb - 1; i >= 0; i--) begin
      if (v[i]) send_bit(slow ? 80 : 62, slow ? 45 : 2);
      else      send_bit(slow ? 40 : 12, slow ? 85 : 2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (px_data !== 24'h0)        begin n_fail++; $display("FAIL reset_px_data: got %h expected 000000", px_data); end
    n_checks++; if (px_num !== 6'd0)          begin n_fail++; $display("FAIL reset_px_num: got %0d expected 0", px_num); end
    n_checks++; if (px_valid !== 1'b0)        begin n_fail++; $display("FAIL reset_px_valid: got %b expected 0", px_valid); end
    n_checks++; if (frame_done !== 1'b0)      begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (frame_px_count !== 7'd0)  begin n_fail++; $display("FAIL reset_frame_px_count: got %0d expected 0", frame_px_count); end
    n_checks++; if (err !== 1'b0)             begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_arm();
    int fd0, er0;
    fd0 = fd_cnt; er0 = err_cnt;
    hold(1'b0, LATCH + 10);
    n_checks++; if (fd_cnt !== fd0)  begin n_fail++; $display("FAIL arm_no_frame_done: got %0d expected %0d", fd_cnt, fd0); end
    n_checks++; if (err_cnt !== er0) begin n_fail++; $display("FAIL arm_no_err: got %0d expected %0d", err_cnt, er0); end
  endtask

  task automatic test_single_pixel();
    int pv0, fd0, er0, fall;
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_bits(24'h00FF00, 24, 1'b1);
    fall = last_fall_cyc;
    hold(1'b0, LATCH + 10);
    n_checks++; if (pv_cnt !== pv0 + 1)               begin n_fail++; $display("FAIL single_px_count: got %0d expected %0d", pv_cnt - pv0, 1); end
    n_checks++; if (log_data[pv0] !== 24'h00FF00)     begin n_fail++; $display("FAIL single_px_data: got %h expected 00ff00", log_data[pv0]); end
    n_checks++; if (log_num[pv0] !== 6'd0)            begin n_fail++; $display("FAIL single_px_num: got %0d expected 0", log_num[pv0]); end
    n_checks++; if (pv_cyc !== fall + 1 + LAT)        begin n_fail++; $display("FAIL single_px_latency: got %0d expected %0d", pv_cyc - fall, 1 + LAT); end
    n_checks++; if (fd_cnt !== fd0 + 1)               begin n_fail++; $display("FAIL single_fd_count: got %0d expected 1", fd_cnt - fd0); end
    n_checks++; if (fd_fpc !== 7'd1)                  begin n_fail++; $display("FAIL single_fpc: got %0d expected 1", fd_fpc); end
    n_checks++; if (fd_cyc !== fall + LATCH + 1 + LAT) begin n_fail++; $display("FAIL single_fd_latency: got %0d expected %0d", fd_cyc - fall, LATCH + 1 + LAT); end
    n_checks++; if (err_cnt !== er0)                  begin n_fail++; $display("FAIL single_no_err: got %0d expected 0", err_cnt - er0); end
  endtask

  task automatic test_max_pixels();
    int pv0, fd0, er0, fall51, fall52;
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt; fall51 = 0;
    for (int k = 0; k < 53; k++) begin
      send_bits(24'(k), 24, 1'b0);
      if (k == 51) fall51 = last_fall_cyc;
    end
    fall52 = last_fall_cyc;
    hold(1'b0, LATCH + 10);
    n_checks++; if (pv_cnt !== pv0 + 52) begin n_fail++; $display("FAIL max_px_count: got %0d expected 52", pv_cnt - pv0); end
    for (int k = 0; k < 52; k++) begin
      n_checks++;
      if ({log_num[pv0 + k], log_data[pv0 + k]} !== {6'(k), 24'(k)}) begin
        n_fail++;
        $display("FAIL max_px_%0d: got num %0d data %h expected num %0d data %h", k, log_num[pv0 + k], log_data[pv0 + k], k, 24'(k));
      end
    end
    n_checks++; if (pv_cyc !== fall51 + 1 + LAT)  begin n_fail++; $display("FAIL max_last_px_latency: got %0d expected %0d", pv_cyc - fall51, 1 + LAT); end
    n_checks++; if (err_cnt !== er0 + 1)          begin n_fail++; $display("FAIL max_overflow_err_count: got %0d expected 1", err_cnt - er0); end
    n_checks++; if (err_cyc !== fall52 + 1 + LAT) begin n_fail++; $display("FAIL max_overflow_err_latency: got %0d expected %0d", err_cyc - fall52, 1 + LAT); end
    n_checks++; if (fd_cnt !== fd0 + 1)           begin n_fail++; $display("FAIL max_fd_count: got %0d expected 1", fd_cnt - fd0); end
    n_checks++; if (fd_fpc !== 7'd52)             begin n_fail++; $display("FAIL max_fpc: got %0d expected 52", fd_fpc); end
  endtask

  task automatic test_partial_pixel();
    int pv0, fd0, er0, bo0, fall;
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt; bo0 = both_cnt;
    send_bits(24'h000ABC, 12, 1'b0);
    fall = last_fall_cyc;
    hold(1'b0, LATCH + 10);
    n_checks++; if (fd_cnt !== fd0 + 1)                begin n_fail++; $display("FAIL partial_fd_count: got %0d expected 1", fd_cnt - fd0); end
    n_checks++; if (err_cnt !== er0 + 1)               begin n_fail++; $display("FAIL partial_err_count: got %0d expected 1", err_cnt - er0); end
    n_checks++; if (both_cnt !== bo0 + 1)              begin n_fail++; $display("FAIL partial_fd_err_same_cycle: got %0d expected 1", both_cnt - bo0); end
    n_checks++; if (fd_fpc !== 7'd0)                   begin n_fail++; $display("FAIL partial_fpc: got %0d expected 0", fd_fpc); end
    n_checks++; if (fd_cyc !== fall + LATCH + 1 + LAT) begin n_fail++; $display("FAIL partial_fd_latency: got %0d expected %0d", fd_cyc - fall, LATCH + 1 + LAT); end
    n_checks++; if (pv_cnt !== pv0)                    begin n_fail++; $display("FAIL partial_no_px: got %0d expected 0", pv_cnt - pv0); end
    send_bits(24'h123456, 24, 1'b0);
    hold(1'b0, 20);
    n_checks++; if (pv_cnt !== pv0 + 1)           begin n_fail++; $display("FAIL recover_px_count: got %0d expected 1", pv_cnt - pv0); end
    n_checks++; if (log_data[pv0] !== 24'h123456) begin n_fail++; $display("FAIL recover_px_data: got %h expected 123456", log_data[pv0]); end
    n_checks++; if (log_num[pv0] !== 6'd0)        begin n_fail++; $display("FAIL recover_px_num: got %0d expected 0", log_num[pv0]); end
  endtask

  task automatic test_long_pulse();
    int pv0, fd0, er0, rise;
    er0 = err_cnt;
    send_bits(24'h000016, 5, 1'b0);
    rise = cyc;
    hold(1'b1, 130);
    hold(1'b0, 3);
    n_checks++; if (err_cnt !== er0 + 1)          begin n_fail++; $display("FAIL long_err_count: got %0d expected 1", err_cnt - er0); end
    n_checks++; if (err_cyc !== rise + 122 + LAT) begin n_fail++; $display("FAIL long_err_latency: got %0d expected %0d", err_cyc - rise, 122 + LAT); end
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_bits(24'hFFFFFF, 24, 1'b0);
    hold(1'b0, 3);
    n_checks++; if (pv_cnt !== pv0)  begin n_fail++; $display("FAIL arm_ignore_px: got %0d expected 0", pv_cnt - pv0); end
    n_checks++; if (err_cnt !== er0) begin n_fail++; $display("FAIL arm_ignore_err: got %0d expected 0", err_cnt - er0); end
    n_checks++; if (fd_cnt !== fd0)  begin n_fail++; $display("FAIL arm_ignore_fd: got %0d expected 0", fd_cnt - fd0); end
    hold(1'b0, LATCH + 10);
  endtask

  task automatic test_glitch_and_sweep();
    int pv0, fd0, er0, fall;
    pv0 = pv_cnt; er0 = err_cnt;
    send_bit(5, 3);
    fall = last_fall_cyc;
    hold(1'b0, 5);
    n_checks++; if (err_cnt !== er0 + 1)        begin n_fail++; $display("FAIL glitch_err_count: got %0d expected 1", err_cnt - er0); end
    n_checks++; if (err_cyc !== fall + 1 + LAT) begin n_fail++; $display("FAIL glitch_err_latency: got %0d expected %0d", err_cyc - fall, 1 + LAT); end
    n_checks++; if (pv_cnt !== pv0)             begin n_fail++; $display("FAIL glitch_no_px: got %0d expected 0", pv_cnt - pv0); end
    hold(1'b0, LATCH + 10);
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_bit(59, 2);
    send_bit(60, 2);
    send_bit(120, 2);
    send_bit(10, 2);
    send_bits(24'h00F0F3, 20, 1'b0);
    hold(1'b0, LATCH + 10);
    n_checks++; if (pv_cnt !== pv0 + 1)           begin n_fail++; $display("FAIL sweep_px_count: got %0d expected 1", pv_cnt - pv0); end
    n_checks++; if (log_data[pv0] !== 24'h60F0F3) begin n_fail++; $display("FAIL sweep_px_data: got %h expected 60f0f3", log_data[pv0]); end
    n_checks++; if (log_num[pv0] !== 6'd0)        begin n_fail++; $display("FAIL sweep_px_num: got %0d expected 0", log_num[pv0]); end
    n_checks++; if (err_cnt !== er0)              begin n_fail++; $display("FAIL sweep_no_err: got %0d expected 0", err_cnt - er0); end
    n_checks++; if (fd_cnt !== fd0 + 1)           begin n_fail++; $display("FAIL sweep_fd_count: got %0d expected 1", fd_cnt - fd0); end
    n_checks++; if (fd_fpc !== 7'd1)              begin n_fail++; $display("FAIL sweep_fpc: got %0d expected 1", fd_fpc); end
  endtask

  task automatic test_reset_mid_frame();
    int pv0, fd0, er0, fall;
    send_bits(24'h0001FF, 9, 1'b0);
    hold(1'b1, 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({px_data, px_num} !== 30'd0)  begin n_fail++; $display("FAIL midreset_data_num: got %h/%0d expected 0/0", px_data, px_num); end
    n_checks++; if (frame_px_count !== 7'd0)     begin n_fail++; $display("FAIL midreset_fpc: got %0d expected 0", frame_px_count); end
    n_checks++; if ({px_valid, frame_done, err} !== 3'b000) begin n_fail++; $display("FAIL midreset_strobes: got %b expected 000", {px_valid, frame_done, err}); end
    reset = 1'b0;
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
    hold(1'b1, 20);
    hold(1'b0, 3);
    send_bits(24'hAAAAAA, 24, 1'b0);
    hold(1'b0, 3);
    n_checks++; if ({pv_cnt, fd_cnt, err_cnt} !== {pv0, fd0, er0}) begin n_fail++; $display("FAIL midreset_quiet: got px %0d fd %0d err %0d expected 0 0 0", pv_cnt - pv0, fd_cnt - fd0, err_cnt - er0); end
    hold(1'b0, LATCH + 10);
    send_bits(24'hC0FFEE, 24, 1'b0);
    fall = last_fall_cyc;
    hold(1'b0, 10);
    n_checks++; if (pv_cnt !== pv0 + 1)           begin n_fail++; $display("FAIL rearm_px_count: got %0d expected 1", pv_cnt - pv0); end
    n_checks++; if (log_data[pv0] !== 24'hC0FFEE) begin n_fail++; $display("FAIL rearm_px_data: got %h expected c0ffee", log_data[pv0]); end
    n_checks++; if (log_num[pv0] !== 6'd0)        begin n_fail++; $display("FAIL rearm_px_num: got %0d expected 0", log_num[pv0]); end
    n_checks++; if (pv_cyc !== fall + 1 + LAT)    begin n_fail++; $display("FAIL rearm_px_latency: got %0d expected %0d", pv_cyc - fall, 1 + LAT); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_single_pixel();
    test_max_pixels();
    test_partial_pixel();
    test_long_pulse();
    test_glitch_and_sweep();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
